// File: rtl/vector_seq_pkg.sv
// Shared types and helpers for the vector display memory address sequencer.
package vector_seq_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, FINISH} vseq_state_t;

    // Channel index width; a single-channel build still needs one bit.
    function automatic int chan_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vector_addr_sequencer_if.sv
// Address stream from the sequencer to the vector memory read port (valid/ready).
interface vector_addr_sequencer_if
    import vector_seq_pkg::*;
#(
    parameter int ADDRESSWIDTH = 10,
    parameter int CHANNELS     = 4,
    localparam int CHW         = chan_width(CHANNELS)
) ();

    logic                    adr_valid;
    logic                    adr_ready;
    logic [ADDRESSWIDTH-1:0] adr_out;
    logic [CHW-1:0]          adr_ch;
    logic                    adr_last;

    modport master (
        output adr_valid,
        output adr_out,
        output adr_ch,
        output adr_last,
        input  adr_ready
    );

    modport slave (
        input  adr_valid,
        input  adr_out,
        input  adr_ch,
        input  adr_last,
        output adr_ready
    );

endinterface

// File: rtl/vector_chan_cfg.sv
// Per-channel base/length register file: synchronous write, combinational read.
module vector_chan_cfg
    import vector_seq_pkg::*;
#(
    parameter int ADDRESSWIDTH = 10,
    parameter int CHANNELS     = 4,
    localparam int CHW         = chan_width(CHANNELS),
    localparam int AW          = ADDRESSWIDTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           we,
    input  logic [CHW-1:0] wr_ch,
    input  logic [AW-1:0]  wr_base,
    input  logic [AW-1:0]  wr_len,
    input  logic [CHW-1:0] rd_ch,
    output logic [AW-1:0]  rd_base,
    output logic [AW-1:0]  rd_len
);

    // Storage covers the full index range so any wr_ch is a legal slot;
    // entries beyond CHANNELS-1 are never read by the sequencer.
    localparam int DEPTH = 1 << CHW;

    logic [AW-1:0] base_mem [DEPTH];
    logic [AW-1:0] len_mem  [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                base_mem[i] <= '0;
                len_mem[i]  <= '0;
            end
        end else if (we) begin
            base_mem[wr_ch] <= wr_base;
            len_mem[wr_ch]  <= wr_len;
        end
    end

    assign rd_base = base_mem[rd_ch];
    assign rd_len  = len_mem[rd_ch];

endmodule

// File: rtl/vector_addr_sequencer.sv
// Walks every non-empty channel list and emits one memory address per accepted beat,
// in one-shot or continuous loop mode.
module vector_addr_sequencer
    import vector_seq_pkg::*;
#(
    parameter int ADDRESSWIDTH = 10,
    parameter int CHANNELS     = 4,
    localparam int CHW         = chan_width(CHANNELS),
    localparam int AW          = ADDRESSWIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_we,
    input  logic [CHW-1:0]                 cfg_ch,
    input  logic [AW-1:0]                  cfg_base,
    input  logic [AW-1:0]                  cfg_len,
    input  logic                           start,
    input  logic                           mode_loop,
    input  logic                           abort,
    vector_addr_sequencer_if.master        adr_bus,
    output logic                           busy,
    output logic                           done
);

    localparam logic [CHW-1:0] LAST_CH = CHW'(CHANNELS - 1);

    vseq_state_t    state;
    logic [CHW-1:0] ch;
    logic [AW-1:0]  idx;
    logic [AW-1:0]  base_q;
    logic [AW-1:0]  len_q;
    logic [AW-1:0]  rd_base;
    logic [AW-1:0]  rd_len;

    logic           adr_valid;
    logic [AW-1:0]  adr_out;
    logic [CHW-1:0] adr_ch;
    logic           adr_last;

    logic [AW-1:0]  idx_next;
    logic [AW-1:0]  len_m1;

    vector_chan_cfg #(
        .ADDRESSWIDTH (ADDRESSWIDTH),
        .CHANNELS     (CHANNELS)
    ) u_cfg (
        .clk     (clk),
        .rst     (rst),
        .we      (cfg_we),
        .wr_ch   (cfg_ch),
        .wr_base (cfg_base),
        .wr_len  (cfg_len),
        .rd_ch   (ch),
        .rd_base (rd_base),
        .rd_len  (rd_len)
    );

    assign idx_next = idx + AW'(1);
    assign len_m1   = len_q - AW'(1);

    // adr_last doubles as the "idx == len-1" flag for the beat on the bus,
    // so the end-of-channel decision needs no extra comparator in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ch        <= '0;
            idx       <= '0;
            base_q    <= '0;
            len_q     <= '0;
            adr_valid <= 1'b0;
            adr_out   <= '0;
            adr_ch    <= '0;
            adr_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                adr_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            ch    <= '0;
                            state <= LOAD;
                            busy  <= 1'b1;
                        end
                    end
                    LOAD: begin
                        base_q <= rd_base;
                        len_q  <= rd_len;
                        idx    <= '0;
                        if (rd_len == '0) begin
                            if (ch == LAST_CH) begin
                                state <= FINISH;
                                done  <= 1'b1;
                            end else begin
                                ch <= ch + CHW'(1);
                            end
                        end else begin
                            state     <= RUN;
                            adr_valid <= 1'b1;
                            adr_out   <= rd_base;
                            adr_ch    <= ch;
                            adr_last  <= (rd_len == AW'(1));
                        end
                    end
                    RUN: begin
                        if (adr_bus.adr_ready) begin
                            if (adr_last) begin
                                adr_valid <= 1'b0;
                                if (ch == LAST_CH) begin
                                    state <= FINISH;
                                    done  <= 1'b1;
                                end else begin
                                    ch    <= ch + CHW'(1);
                                    state <= LOAD;
                                end
                            end else begin
                                idx      <= idx_next;
                                adr_out  <= base_q + idx_next;
                                adr_last <= (idx_next == len_m1);
                            end
                        end
                    end
                    FINISH: begin
                        if (mode_loop) begin
                            ch    <= '0;
                            state <= LOAD;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        adr_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign adr_bus.adr_valid = adr_valid;
    assign adr_bus.adr_out   = adr_out;
    assign adr_bus.adr_ch    = adr_ch;
    assign adr_bus.adr_last  = adr_last;

endmodule
